// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / branch-operand hazard detection and stall sequencing for a 5-stage MIPS pipeline
// Ports: Clk/Rst (async active-high); DEC operand specifiers and use flags, Branch_DEC, Redirect_DEC;
//        EX/MEM producer destination, RegWrite, MemRead; ExtStall freeze input;
//        PCWrite, IFID_Write, IF_Flush, IDEX_Bubble, StallActive controls; saturating StallCycles, FlushCount.
module hazard_control_unit #(
  parameter int REG_W           = 5,
  parameter int CNT_W           = 16,
  parameter int BRANCH_IN_ID    = 1,
  parameter int LOAD_USE_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] Rs_DEC,
  input  logic [REG_W-1:0] Rt_DEC,
  input  logic             UsesRs_DEC,
  input  logic             UsesRt_DEC,
  input  logic             Branch_DEC,
  input  logic             Redirect_DEC,
  input  logic [REG_W-1:0] RegDst_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] RegDst_MEM,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic             ExtStall,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IF_Flush,
  output logic             IDEX_Bubble,
  output logic             StallActive,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [1:0] LU   = 2'(LOAD_USE_CYCLES);
  localparam bit         BR_ID = (BRANCH_IN_ID != 0);
  logic [0:0]       r_state;
  logic [1:0]       r_remain;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_ex_hit;
  logic             w_mem_hit;
  logic [1:0]       w_n_lu;
  logic [1:0]       w_n_br;
  logic [1:0]       w_n;
  logic             w_stall;
  logic             w_flush;
  // $0 is hardwired to zero, so it can never carry a dependency
  assign w_ex_hit  = RegWrite_EX & (RegDst_EX != '0) &
                     ((UsesRs_DEC & (Rs_DEC == RegDst_EX)) | (UsesRt_DEC & (Rt_DEC == RegDst_EX)));
  assign w_mem_hit = RegWrite_MEM & (RegDst_MEM != '0) &
                     ((UsesRs_DEC & (Rs_DEC == RegDst_MEM)) | (UsesRt_DEC & (Rt_DEC == RegDst_MEM)));
  // Branch operands are needed one stage earlier, so producers need more lead time;
  // overlapping hazards take the largest requirement rather than accumulating
  always_comb begin
    w_n_lu = (w_ex_hit & MemRead_EX) ? LU : 2'd0;
    w_n_br = !(BR_ID & Branch_DEC) ? 2'd0 :
             w_ex_hit ? (MemRead_EX ? 2'd2 : 2'd1) :
             (w_mem_hit & MemRead_MEM) ? 2'd1 : 2'd0;
    w_n    = (w_n_lu > w_n_br) ? w_n_lu : w_n_br;
  end
  assign w_stall     = ~Rst & (ExtStall | (r_state == HOLD) | (w_n != 2'd0));
  assign w_flush     = ~Rst & Redirect_DEC & ~w_stall;
  assign StallActive = w_stall;
  assign PCWrite     = ~w_stall;
  assign IFID_Write  = ~w_stall;
  assign IDEX_Bubble = w_stall;
  assign IF_Flush    = w_flush;
  assign StallCycles = r_stall_cnt;
  assign FlushCount  = r_flush_cnt;
  // ExtStall freezes the sequence so it resumes exactly where it stopped
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= RUN;
      r_remain <= 2'd0;
    end else if (!ExtStall) begin
      if (r_state == HOLD) begin
        r_remain <= r_remain - 2'd1;
        if (r_remain == 2'd1) r_state <= RUN;
      end else if (w_n != 2'd0) begin
        r_remain <= w_n - 2'd1;
        if (w_n > 2'd1) r_state <= HOLD;
      end
    end
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench for hazard_control_unit with directed pipeline scenarios
module tb_hazard_control_unit;
  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] Rs_DEC, Rt_DEC, RegDst_EX, RegDst_MEM;
  logic       UsesRs_DEC, UsesRt_DEC, Branch_DEC, Redirect_DEC;
  logic       RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM, ExtStall;
  logic       PCWrite, IFID_Write, IF_Flush, IDEX_Bubble, StallActive;
  logic [3:0] StallCycles, FlushCount;
  typedef struct {
    string      nm;
    logic [4:0] o;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00011;
  localparam logic [4:0] FLUSH = 5'b11100;
  hazard_control_unit #(.REG_W(5), .CNT_W(4), .BRANCH_IN_ID(1), .LOAD_USE_CYCLES(1)) dut (
    .Clk(Clk), .Rst(Rst), .Rs_DEC(Rs_DEC), .Rt_DEC(Rt_DEC),
    .UsesRs_DEC(UsesRs_DEC), .UsesRt_DEC(UsesRt_DEC), .Branch_DEC(Branch_DEC),
    .Redirect_DEC(Redirect_DEC), .RegDst_EX(RegDst_EX), .RegWrite_EX(RegWrite_EX),
    .MemRead_EX(MemRead_EX), .RegDst_MEM(RegDst_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemRead_MEM(MemRead_MEM), .ExtStall(ExtStall), .PCWrite(PCWrite),
    .IFID_Write(IFID_Write), .IF_Flush(IF_Flush), .IDEX_Bubble(IDEX_Bubble),
    .StallActive(StallActive), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] o;
      e = q.pop_front();
      o = {PCWrite, IFID_Write, IF_Flush, IDEX_Bubble, StallActive};
      n_checks++;
      if (o !== e.o || StallCycles !== e.sc || FlushCount !== e.fc) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b sc=%0d fc=%0d, want ctl=%b sc=%0d fc=%0d",
                 e.nm, o, StallCycles, FlushCount, e.o, e.sc, e.fc);
      end
    end
  end
  task automatic clear();
    Rs_DEC = 0; Rt_DEC = 0; UsesRs_DEC = 0; UsesRt_DEC = 0; Branch_DEC = 0; Redirect_DEC = 0;
    RegDst_EX = 0; RegWrite_EX = 0; MemRead_EX = 0;
    RegDst_MEM = 0; RegWrite_MEM = 0; MemRead_MEM = 0; ExtStall = 0;
  endtask
  task automatic cyc(input string nm, input logic [4:0] o, input int sc, input int fc);
    exp_t e;
    e.nm = nm; e.o = o; e.sc = 4'(sc); e.fc = 4'(fc);
    q.push_back(e);
    @(posedge Clk); #1;
  endtask
  task automatic load_ex(input logic [4:0] r);
    RegDst_EX = r; RegWrite_EX = 1; MemRead_EX = 1;
  endtask
  task automatic load_mem(input logic [4:0] r);
    RegDst_EX = 0; RegWrite_EX = 0; MemRead_EX = 0;
    RegDst_MEM = r; RegWrite_MEM = 1; MemRead_MEM = 1;
  endtask
  task automatic beq_rt(input logic [4:0] r);
    Branch_DEC = 1; UsesRs_DEC = 1; UsesRt_DEC = 1; Rs_DEC = 1; Rt_DEC = r;
  endtask
  initial begin
    clear();
    Rst = 1;
    @(posedge Clk); #1;
    load_ex(5); UsesRs_DEC = 1; Rs_DEC = 5;
    cyc("reset_idle", IDLE, 0, 0);
    Rst = 0;
    cyc("lu_stall", STALL, 0, 0);
    clear(); load_mem(5); UsesRs_DEC = 1; Rs_DEC = 5;
    cyc("lu_release", IDLE, 1, 0);
    clear(); load_ex(8); beq_rt(8);
    cyc("br_ldex_1", STALL, 1, 0);
    load_mem(8);
    cyc("br_ldex_2", STALL, 2, 0);
    clear(); beq_rt(8);
    cyc("br_ldex_done", IDLE, 3, 0);
    clear(); load_mem(8); beq_rt(8);
    cyc("br_ldmem_1", STALL, 3, 0);
    clear(); beq_rt(8);
    cyc("br_ldmem_done", IDLE, 4, 0);
    clear(); Branch_DEC = 1; UsesRs_DEC = 1; UsesRt_DEC = 1; RegWrite_EX = 1; RegDst_EX = 0;
    cyc("br_r0_nostall", IDLE, 4, 0);
    clear(); Branch_DEC = 1; UsesRs_DEC = 1; Rs_DEC = 9; RegWrite_EX = 1; RegDst_EX = 9;
    cyc("br_aluex", STALL, 4, 0);
    clear(); UsesRs_DEC = 1; Rs_DEC = 9; RegWrite_EX = 1; RegDst_EX = 9;
    cyc("alu_ex_nonbr", IDLE, 5, 0);
    clear(); Redirect_DEC = 1;
    cyc("redirect_flush", FLUSH, 5, 0);
    clear();
    cyc("after_flush", IDLE, 5, 1);
    load_ex(8); beq_rt(8); Redirect_DEC = 1;
    cyc("redir_stall_1", STALL, 5, 1);
    load_mem(8);
    cyc("redir_stall_2", STALL, 6, 1);
    clear(); Redirect_DEC = 1;
    cyc("redir_deferred", FLUSH, 7, 1);
    clear();
    cyc("redir_done", IDLE, 7, 2);
    Rst = 1;
    cyc("reset_again", IDLE, 0, 0);
    Rst = 0; load_ex(8); beq_rt(8);
    cyc("ext_1", STALL, 0, 0);
    load_mem(8); ExtStall = 1;
    cyc("ext_frz_1", STALL, 1, 0);
    cyc("ext_frz_2", STALL, 2, 0);
    cyc("ext_frz_3", STALL, 3, 0);
    ExtStall = 0;
    cyc("ext_resume", STALL, 4, 0);
    clear(); beq_rt(8);
    cyc("ext_done", IDLE, 5, 0);
    clear(); load_ex(8); beq_rt(8);
    cyc("rst_hold_1", STALL, 5, 0);
    load_mem(8); Rst = 1;
    cyc("rst_in_hold", IDLE, 0, 0);
    Rst = 0; clear(); beq_rt(8);
    cyc("rst_no_residual", IDLE, 0, 0);
    clear(); load_ex(8); RegDst_MEM = 9; RegWrite_MEM = 1; MemRead_MEM = 1;
    Branch_DEC = 1; UsesRs_DEC = 1; UsesRt_DEC = 1; Rs_DEC = 9; Rt_DEC = 8;
    cyc("max_1", STALL, 0, 0);
    cyc("max_2", STALL, 1, 0);
    clear();
    cyc("max_not_sum", IDLE, 2, 0);
    load_ex(5); UsesRs_DEC = 1; Rs_DEC = 5;
    for (int i = 0; i < 18; i++) cyc("sat_stall", STALL, (2 + i > 15) ? 15 : 2 + i, 0);
    clear();
    cyc("sat_hold", IDLE, 15, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised hazard detection and stall sequencer for the 5-stage MIPS pipeline. Branches and jump-registers are resolved in DEC.
- Detects load-use hazards and branch-operand hazards against EX and MEM.
- Inserts multi-cycle stalls through a counter-driven FSM and flushes IF/ID on redirects.
- Keeps saturating stall and flush statistics counters.
- Sits beside the DEC stage and drives the PC, IF/ID and ID/EX pipeline-register controls.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the statistics counters.
- BRANCH_IN_ID, 1: 1 = branch/JR operands are compared in DEC and need extra stalls; 0 = branch/JR are treated as ordinary consumers.
- LOAD_USE_CYCLES, 1, stall cycles for an ordinary consumer after a load in EX. Legal range 1..3.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Rs_DEC  in  REG_W  rs of the instruction in DEC.
- Rt_DEC  in  REG_W  rt of the instruction in DEC.
- UsesRs_DEC  in  1  DEC instruction reads rs.
- UsesRt_DEC  in  1  DEC instruction reads rt.
- Branch_DEC  in  1  DEC instruction is a conditional branch or JR.
- Redirect_DEC  in  1  DEC resolves a taken branch, J, JAL or JR this cycle.
- RegDst_EX  in  REG_W  destination register in EX.
- RegWrite_EX  in  1  EX instruction writes a register.
- MemRead_EX  in  1  EX instruction is a load.
- RegDst_MEM  in  REG_W  destination register in MEM.
- RegWrite_MEM  in  1  MEM instruction writes a register.
- MemRead_MEM  in  1  MEM instruction is a load.
- ExtStall  in  1  external freeze, e.g. a multicycle unit is busy.
- PCWrite  out  1  1 = PC updates.
- IFID_Write  out  1  1 = IF/ID register loads.
- IF_Flush  out  1  1 = IF/ID is zeroed on the next edge.
- IDEX_Bubble  out  1  1 = ID/EX loads zeros (NOP).
- StallActive  out  1  a stall is in effect this cycle.
- StallCycles  out  CNT_W  count of stalled cycles.
- FlushCount  out  CNT_W  count of flush cycles.

Behaviour:
- Match condition for a source operand and a producer stage: Uses* = 1, the producer's RegWrite = 1, specifier equal, and specifier != 0. Register $0 never causes a hazard.
- Required stall cycles N for the current DEC instruction is the maximum over all matching cases:
  - Load in EX, ordinary consumer: N = LOAD_USE_CYCLES.
  - BRANCH_IN_ID=1 and Branch_DEC=1:
    - Load in EX: N = 2.
    - ALU writer (MemRead_EX=0) in EX: N = 1.
    - Load in MEM: N = 1.
  - No match: N = 0.
- FSM states: RUN, HOLD. Internal counter Remain holds 2 bits.
  - RUN with N > 0: stall this cycle (combinational). Load Remain = N-1. Go to HOLD if N > 1, else stay in RUN.
  - HOLD: stall this cycle. Decrement Remain. Return to RUN after the cycle in which Remain = 1 is consumed. Hazard inputs are ignored while in HOLD.
  - Detection is re-evaluated on the first RUN cycle after HOLD.
- Stall outputs: PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1, StallActive = 1.
- ExtStall = 1: same outputs as a stall. The FSM and Remain freeze (no transition, no decrement), and no new detection is latched. When ExtStall falls, the stall sequence resumes exactly where it stopped.
- Flush: IF_Flush = Redirect_DEC & ~StallActive. A redirect during a stall is deferred until the stall ends. Flush and bubble are never both 1 for the same redirect.
- Idle outputs: PCWrite = 1, IFID_Write = 1, IF_Flush = 0, IDEX_Bubble = 0, StallActive = 0.
- Statistics counters:
  - StallCycles increments on every edge where StallActive = 1.
  - FlushCount increments on every edge where IF_Flush = 1.
  - Both saturate at all-ones and never wrap.
- Reset: asynchronous and immediate.
  - State = RUN, Remain = 0, both counters = 0.
  - Outputs take their idle values while Rst = 1.
  - Reset in the middle of a HOLD aborts the stall with no residual stall cycles.
- Simultaneous matches, e.g. load in EX and load in MEM, use the largest N, not the sum.

Test Plan:
- lw $5 in EX (MemRead_EX=1, RegWrite_EX=1, RegDst_EX=5), DEC add reads rs=5 -> exactly 1 cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; StallCycles=1.
- lw $8 in EX, DEC beq using rt=8 with BRANCH_IN_ID=1 -> 2 consecutive stall cycles, then PCWrite=1. Repeat with the load in MEM -> 1 stall cycle.
- DEC beq reads $0 while an EX writer has RegDst_EX=0 -> no stall.
- Taken branch with no hazard (Redirect_DEC=1) -> IF_Flush=1 for one cycle, FlushCount=1.
- Same redirect during a 2-cycle stall -> IF_Flush=0 during the stall and 1 on the first free cycle.
- ExtStall pulsed for 3 cycles in the middle of a 2-cycle load/branch stall -> 5 total stall cycles, StallCycles=5.
- Rst asserted during HOLD -> outputs idle immediately, counters read 0.
- Force StallCycles to all-ones with CNT_W=4, then stall again -> value stays 15.
